// File: rtl/au_pkg.sv
// au_pkg: op encodings and FSM state type shared by au_reduce and au_op16.
package au_pkg;
   localparam logic [1:0] OP_SUB = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_MAX = 2'b10;
   typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;
endpackage

// File: rtl/au_op16.sv
// au_op16: combinational reduce step (sub/add/signed max) with overflow flag.
// Define AU_REDUCE_SAT_EN to clamp add/sub overflow instead of wrapping.
module au_op16
   import au_pkg::*;
#(
   parameter int MSB = 15
) (
   input  logic [1:0]   op,
   input  logic [MSB:0] a,
   input  logic [MSB:0] b,
   output logic [MSB:0] y,
   output logic         ovf
);
   logic         is_sub;
   logic [MSB:0] bx, sum, mx, arith;
   assign is_sub = op == OP_SUB;
   // subtraction as a + ~b + 1, so one overflow rule covers both ops
   assign bx  = is_sub ? ~b : b;
   assign sum = a + bx + {{MSB{1'b0}}, is_sub};
   assign ovf = ~op[1] & (a[MSB] == bx[MSB]) & (sum[MSB] != a[MSB]);
   assign mx  = ($signed(a) > $signed(b)) ? a : b;
`ifdef AU_REDUCE_SAT_EN
   // on overflow the true result has the sign of a
   assign arith = ovf ? (a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}}) : sum;
`else
   assign arith = sum;
`endif
   assign y = op[1] ? mx : arith;
endmodule

// File: rtl/au_reduce.sv
// au_reduce: streams a frame of signed beats through au_op16 and emits the result.
// Saturating arithmetic is selected by AU_REDUCE_SAT_EN (see au_op16).
module au_reduce
   import au_pkg::*;
#(
   parameter int MSB   = 15,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [MSB:0]     in_data,
   input  logic             in_last,
   input  logic [1:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [MSB:0]     out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);
   state_t           state, state_n;
   logic [MSB:0]     acc, acc_d, f_y;
   logic [1:0]       op_q;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic             ovf, ovf_d, f_ovf, xfer;
   au_op16 #(.MSB(MSB)) u_op (
      .op (op_q),
      .a  (acc),
      .b  (in_data),
      .y  (f_y),
      .ovf(f_ovf)
   );
   assign in_ready  = state != OUT;
   assign out_valid = state == OUT;
   assign xfer      = in_valid & in_ready;
   assign acc_d     = (state == IDLE) ? in_data : f_y;
   assign ovf_d     = (state != IDLE) & (ovf | f_ovf);
   assign cnt_d     = (state == IDLE) ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   always_comb begin
      state_n = state;
      if (xfer && in_last)             state_n = OUT;
      else if (xfer && state == IDLE)  state_n = ACC;
      else if (state == OUT && out_ready) state_n = IDLE;
   end
   // result registers load with the final step so they hold outside OUT
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         acc       <= '0;
         op_q      <= OP_SUB;
         cnt       <= '0;
         ovf       <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (xfer) begin
         acc <= acc_d;
         cnt <= cnt_d;
         ovf <= ovf_d;
         if (state == IDLE) op_q <= op;
         if (in_last) begin
            out_data  <= acc_d;
            out_count <= cnt_d;
            out_ovf   <= ovf_d;
         end
      end
endmodule

// File: tb/tb_au_reduce.sv
// tb_au_reduce: table-driven frames plus hold, reset-abort and counter-saturation sequences.
module tb_au_reduce;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic [1:0]  op = 2'b00;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] out_data;
   logic [7:0]  out_count;
   logic        out_ovf;
   int          n_pass = 0;
   int          n_total = 0;

   au_reduce #(.MSB(15), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .op(op), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]       op;
      logic [2:0]       n;
      logic [3:0][15:0] d;
      logic [15:0]      ed;
      logic [7:0]       ec;
      logic             ev;
   } vec_t;

   vec_t vecs[11];

   function automatic vec_t mk(input logic [1:0] o, input logic [2:0] n,
                               input logic [15:0] d0, d1, d2, d3,
                               input logic [15:0] ed, input logic [7:0] ec, input logic ev);
      vec_t v;
      v.op = o; v.n = n; v.d = {d3, d2, d1, d0};
      v.ed = ed; v.ec = ec; v.ev = ev;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // drives n beats; op is only correct on the first beat, later beats carry its inverse
   task automatic send(input logic [1:0] fop, input int n, input logic [3:0][15:0] d);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = d[i];
         in_last  = (i == n - 1);
         op       = (i == 0) ? fop : ~fop;
         @(posedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [15:0] ed, input logic [7:0] ec, input logic ev);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, 32'(out_data), 32'(ed));
      chk({tag, "_count"}, 32'(out_count), 32'(ec));
      chk({tag, "_ovf"}, 32'(out_ovf), 32'(ev));
   endtask

   task automatic drain(input string tag, input logic [15:0] ed);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_idle_hold"}, 32'(out_data), 32'(ed));
   endtask

   initial begin
      logic [3:0][15:0] d;
      vecs[0]  = mk(2'b01, 3, 16'd3,    16'd4,    16'd5,    16'd0, 16'd12,   8'd3, 1'b0);
      vecs[1]  = mk(2'b00, 3, 16'd10,   16'd3,    16'd2,    16'd0, 16'd5,    8'd3, 1'b0);
      vecs[2]  = mk(2'b10, 3, 16'hFFF9, 16'd2,    16'hFFFF, 16'd0, 16'd2,    8'd3, 1'b0);
      vecs[3]  = mk(2'b11, 2, 16'hFFFB, 16'hFFFD, 16'd0,    16'd0, 16'hFFFD, 8'd2, 1'b0);
      vecs[4]  = mk(2'b10, 2, 16'h8000, 16'h7FFF, 16'd0,    16'd0, 16'h7FFF, 8'd2, 1'b0);
      vecs[5]  = mk(2'b01, 1, 16'd7,    16'd0,    16'd0,    16'd0, 16'd7,    8'd1, 1'b0);
      vecs[6]  = mk(2'b00, 4, 16'd100,  16'd1,    16'd2,    16'd3, 16'd94,   8'd4, 1'b0);
`ifdef AU_REDUCE_SAT_EN
      vecs[7]  = mk(2'b01, 2, 16'h7FFF, 16'd1,    16'd0,    16'd0, 16'h7FFF, 8'd2, 1'b1);
      vecs[8]  = mk(2'b00, 2, 16'h8000, 16'd1,    16'd0,    16'd0, 16'h8000, 8'd2, 1'b1);
      vecs[9]  = mk(2'b00, 2, 16'd0,    16'h8000, 16'd0,    16'd0, 16'h7FFF, 8'd2, 1'b1);
      vecs[10] = mk(2'b01, 3, 16'h8000, 16'hFFFF, 16'd1,    16'd0, 16'h8001, 8'd3, 1'b1);
`else
      vecs[7]  = mk(2'b01, 2, 16'h7FFF, 16'd1,    16'd0,    16'd0, 16'h8000, 8'd2, 1'b1);
      vecs[8]  = mk(2'b00, 2, 16'h8000, 16'd1,    16'd0,    16'd0, 16'h7FFF, 8'd2, 1'b1);
      vecs[9]  = mk(2'b00, 2, 16'd0,    16'h8000, 16'd0,    16'd0, 16'h8000, 8'd2, 1'b1);
      vecs[10] = mk(2'b01, 3, 16'h8000, 16'hFFFF, 16'd1,    16'd0, 16'h8000, 8'd3, 1'b1);
`endif
      // reset state
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_count", 32'(out_count), 32'd0);
      chk("rst_out_ovf", 32'(out_ovf), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", 32'(out_valid), 32'd0);

      for (int i = 0; i < 11; i++) begin
         send(vecs[i].op, int'(vecs[i].n), vecs[i].d);
         check_out($sformatf("v%0d", i), vecs[i].ed, vecs[i].ec, vecs[i].ev);
         drain($sformatf("v%0d", i), vecs[i].ed);
      end

      // hold with out_ready low while a beat is offered; it must wait for IDLE
      d = {16'd0, 16'd0, 16'd2, 16'd1};
      send(2'b01, 2, d);
      @(negedge clk);
      in_valid = 1'b1; in_data = 16'd100; in_last = 1'b1; op = 2'b01;
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("hold%0d_data", k), 32'(out_data), 32'd3);
         chk($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("hold_idle_valid", 32'(out_valid), 32'd0);
      chk("hold_idle_in_ready", 32'(in_ready), 32'd1);
      chk("hold_idle_data", 32'(out_data), 32'd3);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      check_out("next", 16'd100, 8'd1, 1'b0);
      drain("next", 16'd100);

      // reset after two beats of a four-beat frame
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_data = 16'(i + 1); in_last = 1'b0; op = 2'b01;
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("abort_valid", 32'(out_valid), 32'd0);
      chk("abort_data", 32'(out_data), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_out", 32'(out_valid), 32'd0);
      end
      d = {16'd0, 16'd0, 16'd0, 16'd7};
      send(2'b01, 1, d);
      check_out("after_abort", 16'd7, 8'd1, 1'b0);
      drain("after_abort", 16'd7);

      // 300 beats of 1 saturate an 8-bit counter
      for (int i = 0; i < 300; i++) begin
         in_valid = 1'b1; in_data = 16'd1; in_last = (i == 299); op = 2'b01;
         @(negedge clk);
      end
      in_valid = 1'b0; in_last = 1'b0;
      check_out("long", 16'd300, 8'd255, 1'b0);
      drain("long", 16'd300);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
